// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - game flow FSM (screens, level, lives) and ROM pixel source select
// Scene, level and lives advance on keyboard events and play-datapath result pulses.

module screen_sequencer #(
  parameter int NUM_LEVELS = 4,
  parameter int LIVES      = 3,
  parameter int PASS_HOLD  = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic        keydown,
  input  logic [8:0]  last_change,
  input  logic        level_pass,
  input  logic        level_fail,
  input  logic        video_valid,
  input  logic [11:0] pix_title,
  input  logic [11:0] pix_play,
  input  logic [11:0] pix_pass,
  input  logic [11:0] pix_fail,
  output logic [11:0] pixel_out,
  output logic [2:0]  scene,
  output logic [2:0]  level,
  output logic [1:0]  lives,
  output logic        game_rst
);

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_PLAY  = 3'd1,
    S_PASS  = 3'd2,
    S_FAIL  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } scene_e;

  localparam logic [8:0] KEY_ENTER  = 9'h05A;
  localparam logic [8:0] KEY_SCOLON = 9'h04C;
  localparam int         HW         = (PASS_HOLD > 2) ? $clog2(PASS_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(PASS_HOLD - 1);
  localparam logic [2:0]    LAST_LEVEL = 3'(NUM_LEVELS - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  scene_e        scene_q;
  logic [2:0]    level_q;
  logic [1:0]    lives_q;
  logic          game_rst_q;
  logic [HW-1:0] hold_q;
  logic          enter_q;
  logic          scolon_q;
  logic [2:0]    scene_dly_q;
  logic          valid_dly_q;
  logic [11:0]   pixel_q;
  logic [11:0]   pix_src_d;

  logic enter_match, scolon_match, enter_evt, scolon_evt;

  // A held key yields one event; it re-arms only after the match drops.
  assign enter_match  = ready & keydown & (last_change == KEY_ENTER);
  assign scolon_match = ready & keydown & (last_change == KEY_SCOLON);
  assign enter_evt    = enter_match & ~enter_q;
  assign scolon_evt   = scolon_match & ~scolon_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scene_q    <= S_TITLE;
      level_q    <= 3'd0;
      lives_q    <= LIVES_INIT;
      game_rst_q <= 1'b0;
      hold_q     <= '0;
      enter_q    <= 1'b0;
      scolon_q   <= 1'b0;
    end else begin
      enter_q    <= enter_match;
      scolon_q   <= scolon_match;
      game_rst_q <= 1'b0;
      case (scene_q)
        S_TITLE: begin
          if (enter_evt) begin
            scene_q    <= S_PLAY;
            level_q    <= 3'd0;
            lives_q    <= LIVES_INIT;
            game_rst_q <= 1'b1;
          end
        end
        S_PLAY: begin
          if (level_pass) begin
            scene_q <= S_PASS;
            hold_q  <= '0;
          end else if (level_fail) begin
            if (lives_q == 2'd1) begin
              scene_q <= S_OVER;
              lives_q <= 2'd0;
            end else begin
              scene_q <= S_FAIL;
              lives_q <= lives_q - 2'd1;
            end
          end
        end
        S_PASS: begin
          if (enter_evt || hold_q == HOLD_LAST) begin
            hold_q <= '0;
            if (level_q == LAST_LEVEL) begin
              scene_q <= S_WIN;
            end else begin
              scene_q    <= S_PLAY;
              level_q    <= level_q + 3'd1;
              game_rst_q <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        S_FAIL: begin
          if (scolon_evt) begin
            scene_q    <= S_PLAY;
            game_rst_q <= 1'b1;
          end
        end
        S_OVER, S_WIN: begin
          if (scolon_evt) scene_q <= S_TITLE;
        end
        default: scene_q <= S_TITLE;
      endcase
    end
  end

  // Scene and valid are delayed one cycle to line up with the ROM read latency.
  always_comb begin
    pix_src_d = 12'h000;
    case (scene_dly_q)
      S_TITLE:        pix_src_d = pix_title;
      S_PLAY:         pix_src_d = pix_play;
      S_PASS, S_WIN:  pix_src_d = pix_pass;
      S_FAIL, S_OVER: pix_src_d = pix_fail;
      default:        pix_src_d = 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scene_dly_q <= 3'd0;
      valid_dly_q <= 1'b0;
      pixel_q     <= 12'h000;
    end else begin
      scene_dly_q <= scene_q;
      valid_dly_q <= video_valid;
      pixel_q     <= valid_dly_q ? pix_src_d : 12'h000;
    end
  end

  assign pixel_out = pixel_q;
  assign scene     = scene_q;
  assign level     = level_q;
  assign lives     = lives_q;
  assign game_rst  = game_rst_q;

endmodule
